// File: rtl/serial_subtractor_if.sv
// Start/done handshake and result bus for serial_subtractor.
// Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow flag ovf.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] bout;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b,
`ifdef SERIAL_SUB_OVF_EN
    input  ovf,
`endif
    input  busy, done, d, bout, borrow
  );

  modport slave (
    input  start, a, b,
`ifdef SERIAL_SUB_OVF_EN
    output ovf,
`endif
    output busy, done, d, bout, borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b, one bit per clock through a single
// full-subtractor cell and a registered borrow. Also reports the per-bit
// borrow vector so results line up with the ripple adder's carry vector.
// Optional macro SERIAL_SUB_OVF_EN adds a registered signed-overflow flag.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  serial_subtractor_if.slave bus
);
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bflop_q, bflop_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] bout_q, bout_d;
  logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic a_bit, b_bit, diff_bit, bo;
  logic last_bit;

  // Full-subtractor cell on the currently selected bit
  always_comb begin
    a_bit    = a_q[cnt_q];
    b_bit    = b_q[cnt_q];
    diff_bit = a_bit ^ b_bit ^ bflop_q;
    bo       = (~a_bit & b_bit) | (~a_bit & bflop_q) | (b_bit & bflop_q);
    last_bit = (cnt_q == CntW'(WIDTH - 1));
  end

  // Next-state and datapath update; everything holds unless a state acts on it
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    bflop_d  = bflop_q;
    d_d      = d_q;
    bout_d   = bout_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d  = StShift;
          a_d      = bus.a;
          b_d      = bus.b;
          cnt_d    = '0;
          bflop_d  = 1'b0;
          d_d      = '0;
          bout_d   = '0;
          borrow_d = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = 1'b0;
`endif
        end
      end
      StShift: begin
        d_d[cnt_q]    = diff_bit;
        bout_d[cnt_q] = bo;
        bflop_d       = bo;
        if (last_bit) begin
          state_d  = StDone;
          borrow_d = bo;
`ifdef SERIAL_SUB_OVF_EN
          // diff_bit is the result MSB being produced on this edge
          ovf_d    = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ diff_bit);
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand, counter, borrow and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      bflop_q  <= 1'b0;
      d_q      <= '0;
      bout_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      bflop_q  <= bflop_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy   = (state_q == StShift);
  assign bus.done   = (state_q == StDone);
  assign bus.d      = d_q;
  assign bus.bout   = bout_q;
  assign bus.borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4). Honours SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;
  localparam int unsigned W = 4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   cyc;
  int   busy_cnt;
  int   results;
  logic [W-1:0] sum_m;
  logic [W-1:0] carry_m;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent ripple-adder model: sum and per-bit carry of x + y
  task automatic adder_model(input logic [W-1:0] x, input logic [W-1:0] y,
                             output logic [W-1:0] s, output logic [W-1:0] c);
    logic cin;
    cin = 1'b0;
    for (int i = 0; i < W; i++) begin
      s[i] = x[i] ^ y[i] ^ cin;
      c[i] = (x[i] & y[i]) | (x[i] & cin) | (y[i] & cin);
      cin  = c[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start an operation, optionally keeping start high, and wait for done
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit hold);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    step();
    if (!hold) bus.start = 1'b0;
    cyc      = 1;
    busy_cnt = 0;
    while (!bus.done && cyc < 20) begin
      if (bus.busy) busy_cnt++;
      step();
      cyc++;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    step();
    step();
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_d", {28'd0, bus.d}, 32'd0);
    check("reset_bout", {28'd0, bus.bout}, 32'd0);
    check("reset_borrow", {31'd0, bus.borrow}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset_ovf", {31'd0, bus.ovf}, 32'd0);
`endif
    rst = 1'b0;
    step();

    // 2 - 1 with latency check
    run_op(4'b0010, 4'b0001, 1'b0);
    check("t1_latency", cyc, 5);
    check("t1_busy_cycles", busy_cnt, 4);
    check("t1_done", {31'd0, bus.done}, 32'd1);
    check("t1_d", {28'd0, bus.d}, 32'h1);
    check("t1_bout", {28'd0, bus.bout}, 32'h1);
    check("t1_borrow", {31'd0, bus.borrow}, 32'd0);
    step();
    check("t1_done_one_cycle", {31'd0, bus.done}, 32'd0);
    step();
    step();
    check("t1_d_held", {28'd0, bus.d}, 32'h1);

    // 0 - 1 wraps with full borrow chain
    run_op(4'b0000, 4'b0001, 1'b0);
    check("t2_d", {28'd0, bus.d}, 32'hf);
    check("t2_bout", {28'd0, bus.bout}, 32'hf);
    check("t2_borrow", {31'd0, bus.borrow}, 32'd1);
    step();

    // Equal operands, start held high through DONE
    run_op(4'b0101, 4'b0101, 1'b1);
    results = bus.done ? 1 : 0;
    check("t3_d", {28'd0, bus.d}, 32'h0);
    check("t3_bout", {28'd0, bus.bout}, 32'h0);
    check("t3_borrow", {31'd0, bus.borrow}, 32'd0);
    step();
    check("t3_idle_after_done_busy", {31'd0, bus.busy}, 32'd0);
    check("t3_idle_after_done_done", {31'd0, bus.done}, 32'd0);
    step();
    check("t3_reaccept_busy", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 20) begin
      step();
      cyc++;
    end
    if (bus.done) results++;
    check("t3_results", results, 2);
    check("t3_second_latency", cyc, 4);
    step();

    // Signed overflow case and non-overflow rerun
    run_op(4'b1000, 4'b0001, 1'b0);
    check("t4_d", {28'd0, bus.d}, 32'h7);
    check("t4_bout", {28'd0, bus.bout}, 32'h7);
    check("t4_borrow", {31'd0, bus.borrow}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("t4_ovf", {31'd0, bus.ovf}, 32'd1);
`endif
    step();
    run_op(4'b0011, 4'b0001, 1'b0);
    check("t4b_d", {28'd0, bus.d}, 32'h2);
`ifdef SERIAL_SUB_OVF_EN
    check("t4b_ovf", {31'd0, bus.ovf}, 32'd0);
`endif
    step();

    // Asynchronous reset during the second SHIFT cycle
    bus.a     = 4'b1111;
    bus.b     = 4'b0001;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    check("t5_pre_reset_busy", {31'd0, bus.busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_busy", {31'd0, bus.busy}, 32'd0);
    check("t5_async_done", {31'd0, bus.done}, 32'd0);
    check("t5_async_d", {28'd0, bus.d}, 32'h0);
    check("t5_async_bout", {28'd0, bus.bout}, 32'h0);
    check("t5_async_borrow", {31'd0, bus.borrow}, 32'd0);
    results = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.done) results++;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.done) results++;
    end
    check("t5_no_done", results, 0);
    run_op(4'b1111, 4'b0001, 1'b0);
    check("t5_after_d", {28'd0, bus.d}, 32'he);
    check("t5_after_bout", {28'd0, bus.bout}, 32'h0);
    check("t5_after_borrow", {31'd0, bus.borrow}, 32'd0);
    step();

    // Operand changes after acceptance are ignored
    bus.a     = 4'b0010;
    bus.b     = 4'b0001;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.a = 4'b1111;
    bus.b = 4'b1111;
    cyc = 0;
    while (!bus.done && cyc < 20) begin
      step();
      cyc++;
    end
    check("t6_d", {28'd0, bus.d}, 32'h1);
    check("t6_borrow", {31'd0, bus.borrow}, 32'd0);
    step();

    // Exhaustive sweep cross-checked against the ripple adder
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        run_op(4'(x), 4'(y), 1'b0);
        adder_model(bus.d, 4'(y), sum_m, carry_m);
        check($sformatf("sweep_sum_%0d_%0d", x, y), {28'd0, sum_m}, 32'(x));
        check($sformatf("sweep_bout_%0d_%0d", x, y), {28'd0, bus.bout}, {28'd0, carry_m});
        check($sformatf("sweep_borrow_%0d_%0d", x, y), {31'd0, bus.borrow},
              (x < y) ? 32'd1 : 32'd0);
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor; the inverse-direction companion to the team's ripple parallel adder. Computes d = a - b one bit per clock using a single full-subtractor cell and a registered borrow.
- Outputs a per-bit borrow vector alongside the difference, in the same form as the adder's per-bit carry vector, so results can be cross-checked against the adder (a = d + b).
- Sits as a small multi-cycle arithmetic unit behind a start/done handshake.

Parameters:
- WIDTH, 4, operand/result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request pulse/level; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when the result is valid.
- d  output  WIDTH  difference a - b (mod 2^WIDTH).
- bout  output  WIDTH  per-bit borrow-out; bout[i] is the borrow from bit i.
- borrow  output  1  final borrow (= bout[WIDTH-1]); 1 means a < b unsigned.

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE; busy=0, done=0, d=0, bout=0, borrow=0; internal operand regs, bit counter and borrow flop cleared. Operation in flight is discarded; no done is produced for it.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if start=1 at a rising edge, latch a and b, clear the borrow flop, counter=0, clear d and bout, go to SHIFT. Otherwise stay in IDLE; d, bout and borrow hold their last result.
- SHIFT: each edge processes bit i=counter.
  - d[i] = a[i] ^ b[i] ^ bin
  - bo = (~a[i] & b[i]) | (~a[i] & bin) | (b[i] & bin)
  - bout[i] = bo; borrow flop <= bo.
  - bin = borrow flop; it is 0 for bit 0.
  - If counter == WIDTH-1, go to DONE and register borrow <= bo; else counter++.
- DONE: done=1 for exactly this one cycle, busy=0; next edge goes to IDLE unconditionally.
- Latency: start sampled at edge N. busy=1 after edges N..N+WIDTH-1. done=1 after edge N+WIDTH, for one cycle. With WIDTH=4, the accepting edge plus 4 processing edges gives 5 cycles from start to done.
- start while busy or in DONE: ignored; no queueing. a and b changes after acceptance have no effect.
- d, bout and borrow are stable and valid from done rising until the next accepted start.
- Arithmetic is unsigned modulo 2^WIDTH. a == b gives d=0, bout=0, borrow=0.

Optional Feature:
- SERIAL_SUB_OVF_EN defined: adds output port ovf (1 bit).
  - Signed two's-complement overflow = (a[W-1] ^ b[W-1]) & (a[W-1] ^ d[W-1]), registered on entry to DONE.
  - Held with d; reset to 0; cleared on an accepted start.
- Not defined: port absent; no overflow logic.

Test Plan:
- WIDTH=4, a=0010, b=0001, start pulse: busy high 4 cycles, done pulse 5 cycles after start, d=0001, bout=0001, borrow=0.
- a=0000, b=0001: d=1111, bout=1111, borrow=1.
- a=0101, b=0101: d=0000, bout=0000, borrow=0. Then hold start high through DONE: exactly one result per IDLE acceptance, and a new operation is accepted only on the edge after done.
- a=1000, b=0001, SERIAL_SUB_OVF_EN defined: d=0111, bout=0111, borrow=0, ovf=1. Rerun with a=0011, b=0001: ovf=0.
- Assert rst at the 2nd SHIFT cycle of a=1111, b=0001: all outputs 0 immediately (asynchronous), no done. After release, a=1111, b=0001 gives d=1110, borrow=0.
- Change a and b mid-SHIFT (a=0010, b=0001 then a=1111, b=1111): result still d=0001. Also run a random sweep of all 256 pairs checking d + b (via the parallel adder model) == a mod 16.
